// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 constants, converter state encoding and operand classification
package fp32_pkg;
  localparam int FP32_BIAS    = 127;
  localparam int FP32_EXP_MAX = 255;
  localparam int FP32_FRAC_W  = 23;
  localparam int FP32_EXP_W   = 8;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_ALIGN  = 3'd2;
  localparam logic [2:0] ST_SIGN   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

  function automatic fp_class_e fp32_classify(input logic [31:0] x);
    logic [FP32_EXP_W-1:0]  ex;
    logic [FP32_FRAC_W-1:0] fr;
    ex = x[30:23];
    fr = x[22:0];
    if (ex == 8'(FP32_EXP_MAX)) return (fr != '0) ? CLS_NAN : CLS_INF;
    if (ex == '0) return CLS_ZERO;
    return CLS_NORM;
  endfunction
endpackage

// File: rtl/fp32_align_shifter.sv
// rtl/fp32_align_shifter.sv - aligns the 24-bit significand to an integer magnitude, truncating
module fp32_align_shifter
  import fp32_pkg::*;
(
  input  logic [23:0]       m,
  input  logic signed [8:0] e,
  input  logic              frac_nz,
  output logic [31:0]       mag,
  output logic              inexact,
  output logic              ovf_cand
);
  logic [4:0]  rsh;
  logic [4:0]  lsh;
  logic [23:0] lost_mask;

  always_comb begin
    mag       = '0;
    inexact   = 1'b0;
    ovf_cand  = 1'b0;
    // Shift amounts are only meaningful inside their own exponent window.
    rsh       = 5'd23 - e[4:0];
    lsh       = e[4:0] - 5'd23;
    lost_mask = (24'd1 << rsh) - 24'd1;
    if (e[8]) begin
      inexact = (m != '0) || frac_nz;
    end else if (e <= 9'sd23) begin
      mag     = {8'd0, m >> rsh};
      inexact = |(m & lost_mask);
    end else if (e <= 9'sd30) begin
      mag     = {8'd0, m} << lsh;
    end else begin
      ovf_cand = 1'b1;
    end
  end
endmodule

// File: rtl/fp32_to_int_fsm.sv
// rtl/fp32_to_int_fsm.sv - multi-cycle FP32 to signed int32 converter, truncating, r_i/r_o handshake
module fp32_to_int_fsm
  import fp32_pkg::*;
#(
  parameter logic SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_i,
  input  logic [31:0] a,
  output logic [31:0] res,
  output logic        r_o,
  output logic        busy,
  output logic        ovf,
  output logic        inexact
);
  logic [2:0]        state;
  logic [31:0]       a_q;
  logic              s_q;
  logic signed [8:0] e_q;
  logic [23:0]       m_q;
  logic              frac_nz_q;
  fp_class_e         cls_q;
  logic [31:0]       mag_q;
  logic              inx_q;
  logic              ovfc_q;
  logic [31:0]       res_n;
  logic              ovf_n;
  logic              inx_n;

  logic [31:0] sh_mag;
  logic        sh_inx;
  logic        sh_ovf;
  logic [31:0] sg_res;
  logic        sg_ovf;
  logic        sg_inx;

  fp32_align_shifter u_shift (
    .m        (m_q),
    .e        (e_q),
    .frac_nz  (frac_nz_q),
    .mag      (sh_mag),
    .inexact  (sh_inx),
    .ovf_cand (sh_ovf)
  );

  always_comb begin
    sg_res = s_q ? (32'd0 - mag_q) : mag_q;
    sg_ovf = 1'b0;
    sg_inx = inx_q;
    if (cls_q == CLS_NAN) begin
      sg_res = INT_MIN;
      sg_ovf = 1'b1;
      sg_inx = 1'b0;
    end else if (ovfc_q) begin
      sg_inx = 1'b0;
      // -2^31 is the one out-of-window value that is exactly representable.
      if (s_q && (e_q == 9'sd31) && !frac_nz_q) begin
        sg_res = INT_MIN;
      end else begin
        sg_ovf = 1'b1;
        sg_res = (SAT_EN && !s_q) ? INT_MAX : INT_MIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      s_q       <= 1'b0;
      e_q       <= '0;
      m_q       <= '0;
      frac_nz_q <= 1'b0;
      cls_q     <= CLS_ZERO;
      mag_q     <= '0;
      inx_q     <= 1'b0;
      ovfc_q    <= 1'b0;
      res_n     <= '0;
      ovf_n     <= 1'b0;
      inx_n     <= 1'b0;
      res       <= '0;
      r_o       <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          r_o <= 1'b0;
          if (r_i) begin
            a_q   <= a;
            busy  <= 1'b1;
            state <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          s_q       <= a_q[31];
          e_q       <= $signed({1'b0, a_q[30:23]}) - $signed(9'(FP32_BIAS));
          m_q       <= (a_q[30:23] == '0) ? 24'd0 : {1'b1, a_q[22:0]};
          frac_nz_q <= (a_q[22:0] != '0);
          cls_q     <= fp32_classify(a_q);
          state     <= ST_ALIGN;
        end
        ST_ALIGN: begin
          mag_q  <= sh_mag;
          inx_q  <= sh_inx;
          ovfc_q <= sh_ovf;
          state  <= ST_SIGN;
        end
        ST_SIGN: begin
          res_n <= sg_res;
          ovf_n <= sg_ovf;
          inx_n <= sg_inx;
          state <= ST_DONE;
        end
        ST_DONE: begin
          res     <= res_n;
          ovf     <= ovf_n;
          inexact <= inx_n;
          r_o     <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
